// File: rtl/game_frame_ctrl.sv
// rtl/game_frame_ctrl.sv - frame-paced game sequencer: menu, erase/update/check/draw loop, score
// Frame ticks come from a free-running divider while a game is live; one late tick may be queued.
module game_frame_ctrl #(
  parameter int FRAME_DIV = 833333
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       grav,
  input  logic       collide,
  input  logic       erase_done,
  input  logic       draw_done,
  output logic       startgame,
  output logic       init_game,
  output logic       erase_req,
  output logic       update_en,
  output logic       draw_req,
  output logic       grav_dir,
  output logic       endgame,
  output logic [7:0] score,
  output logic       overrun
);

  typedef enum logic [3:0] {
    S_MENU, S_MENU_WAIT, S_START, S_WAIT_TICK, S_ERASE,
    S_UPDATE, S_CHECK, S_DRAW, S_OVER
  } state_t;

  localparam logic [19:0] LAST = 20'(FRAME_DIV - 1);

  state_t      state;
  state_t      state_nx;
  logic [19:0] frame_cnt;
  logic        tick_pending;
  logic        grav_flip_req;
  logic        go_q;
  logic        grav_q;
  logic        go_armed;
  logic        grav_dir_q;
  logic        overrun_q;
  logic [7:0]  score_q;
  logic        tick;
  logic        go_rise;
  logic        grav_rise;

  // go_armed blocks a button that was already held when reset released
  assign go_rise   = go & ~go_q & go_armed;
  assign grav_rise = grav & ~grav_q;
  assign tick      = startgame && (frame_cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_MENU;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_MENU:      if (go_rise) state_nx = S_MENU_WAIT;
      S_MENU_WAIT: if (!go) state_nx = S_START;
      S_START:     state_nx = S_WAIT_TICK;
      S_WAIT_TICK: if (tick || tick_pending) state_nx = S_ERASE;
      S_ERASE:     if (erase_done) state_nx = S_UPDATE;
      S_UPDATE:    state_nx = S_CHECK;
      S_CHECK:     state_nx = collide ? S_OVER : S_DRAW;
      S_DRAW:      if (draw_done) state_nx = S_WAIT_TICK;
      S_OVER:      if (go_rise) state_nx = S_MENU;
      default:     state_nx = S_MENU;
    endcase
  end

  always_comb begin
    startgame = 1'b1;
    init_game = 1'b0;
    erase_req = 1'b0;
    update_en = 1'b0;
    draw_req  = 1'b0;
    endgame   = 1'b0;
    case (state)
      S_MENU, S_MENU_WAIT: startgame = 1'b0;
      S_OVER: begin
        startgame = 1'b0;
        endgame   = 1'b1;
      end
      S_START:  init_game = 1'b1;
      S_ERASE:  erase_req = 1'b1;
      S_UPDATE: update_en = 1'b1;
      S_DRAW:   draw_req  = 1'b1;
      default:  ;
    endcase
    score    = score_q;
    grav_dir = grav_dir_q;
    overrun  = overrun_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt     <= '0;
      tick_pending  <= 1'b0;
      grav_flip_req <= 1'b0;
      go_q          <= 1'b0;
      grav_q        <= 1'b0;
      go_armed      <= 1'b0;
      grav_dir_q    <= 1'b0;
      overrun_q     <= 1'b0;
      score_q       <= '0;
    end else begin
      go_q   <= go;
      grav_q <= grav;
      if (!go) begin
        go_armed <= 1'b1;
      end

      if (!startgame || frame_cnt == LAST) begin
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 20'd1;
      end

      overrun_q <= tick && tick_pending;

      // a new game starts with no stale frame queued from the last one
      if (state == S_START) begin
        tick_pending <= 1'b0;
      end else if (state == S_WAIT_TICK && state_nx == S_ERASE) begin
        tick_pending <= 1'b0;
      end else if (tick) begin
        tick_pending <= 1'b1;
      end

      // an edge landing in UPDATE itself is kept for the next frame
      if (state == S_START) begin
        grav_flip_req <= 1'b0;
        grav_dir_q    <= 1'b0;
      end else if (state == S_UPDATE) begin
        if (grav_flip_req) begin
          grav_dir_q <= ~grav_dir_q;
        end
        grav_flip_req <= grav_rise;
      end else if (grav_rise) begin
        grav_flip_req <= 1'b1;
      end

      if (state == S_START) begin
        score_q <= '0;
      end else if (state == S_UPDATE && score_q != 8'hFF) begin
        score_q <= score_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_frame_ctrl.sv
// tb/tb_game_frame_ctrl.sv - directed/randomized bench for game_frame_ctrl with a frame-timing model
module tb_game_frame_ctrl;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic       grav;
  logic       collide;
  logic       erase_done;
  logic       draw_done;
  logic       startgame;
  logic       init_game;
  logic       erase_req;
  logic       update_en;
  logic       draw_req;
  logic       grav_dir;
  logic       endgame;
  logic [7:0] score;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc;
  int e_prev;
  int d_prev;
  int ov_seen;
  int ov_exp;
  int m_frames;
  int m_grav;
  int m_flip;

  game_frame_ctrl #(.FRAME_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .go(go), .grav(grav), .collide(collide),
    .erase_done(erase_done), .draw_done(draw_done), .startgame(startgame),
    .init_game(init_game), .erase_req(erase_req), .update_en(update_en),
    .draw_req(draw_req), .grav_dir(grav_dir), .endgame(endgame),
    .score(score), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (overrun === 1'b1) ov_seen++;
  endtask

  function automatic int ticks_upto(input int b);
    return (b - s_cyc) / DIV;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({startgame, init_game, erase_req, update_en, draw_req,
                grav_dir, endgame, overrun, score});
  endfunction

  task automatic start_game();
    int w;
    go = 1'b1;
    step();
    chk("menu_wait_idle", 32'(startgame), 32'd0);
    step();
    step();
    go = 1'b0;
    w = 0;
    while (init_game !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    chk("init_game_seen", 32'(init_game), 32'd1);
    chk("startgame_in_start", 32'(startgame), 32'd1);
    s_cyc  = cyc;
    e_prev = cyc;
    step();
    chk("init_one_pulse", 32'(init_game), 32'd0);
    chk("score_cleared", 32'(score), 32'd0);
    chk("grav_cleared", 32'(grav_dir), 32'd0);
    d_prev   = cyc;
    ov_seen  = 0;
    ov_exp   = 0;
    m_frames = 0;
    m_grav   = 0;
    m_flip   = 0;
  endtask

  // Frame start = later of the first tick after the previous start and the cycle
  // after WAIT_TICK is re-entered; every extra tick in that window is an overrun.
  task automatic run_frame(input int le, input int ld, input bit col, input int gp, input bit g_upd);
    int w;
    int nt;
    int e_exp;
    int n;
    nt    = s_cyc + DIV * (ticks_upto(e_prev) + 1);
    e_exp = (nt > d_prev + 1) ? nt : d_prev + 1;
    n     = ticks_upto(d_prev + 1) - ticks_upto(e_prev);
    if (n > 1) ov_exp += n - 1;
    w = 0;
    while (erase_req !== 1'b1 && w < 64) begin
      collide   = 1'($urandom);
      draw_done = 1'($urandom);
      step();
      w++;
    end
    chk("erase_start_cycle", 32'(cyc), 32'(e_exp));
    chk("overrun_count", 32'(ov_seen), 32'(ov_exp));
    chk("no_draw_in_erase", 32'(draw_req), 32'd0);
    e_prev = e_exp;
    for (int i = 0; i < le; i++) begin
      grav      = (i < 2 * gp) && (i % 2 == 0);
      draw_done = 1'($urandom);
      collide   = 1'($urandom);
      step();
      chk("erase_hold", 32'(erase_req), 32'd1);
    end
    grav       = 1'b0;
    erase_done = 1'b1;
    draw_done  = 1'b0;
    step();
    chk("update_pulse", 32'({update_en, erase_req}), 32'd2);
    erase_done = 1'b0;
    grav       = g_upd;
    collide    = col;
    if (gp > 0) m_flip = 1;
    m_grav   = m_grav ^ m_flip;
    m_flip   = g_upd;
    m_frames = m_frames + 1;
    step();
    grav = 1'b0;
    chk("update_one_cycle", 32'(update_en), 32'd0);
    chk("score", 32'(score), 32'((m_frames > 255) ? 255 : m_frames));
    chk("grav_dir", 32'(grav_dir), 32'(m_grav));
    step();
    if (col) begin
      chk("over_no_draw", 32'({endgame, draw_req}), 32'd2);
      collide = 1'b0;
      return;
    end
    chk("draw_req_up", 32'({endgame, draw_req}), 32'd1);
    for (int i = 0; i < ld; i++) begin
      erase_done = 1'($urandom);
      collide    = 1'($urandom);
      step();
      chk("draw_hold", 32'(draw_req), 32'd1);
    end
    draw_done  = 1'b1;
    erase_done = 1'b0;
    step();
    chk("draw_drop", 32'(draw_req), 32'd0);
    d_prev    = cyc;
    draw_done = 1'b0;
    collide   = 1'b0;
  endtask

  initial begin
    int w;
    resetn = 1'b0; go = 1'b1; grav = 1'b0; collide = 1'b0;
    erase_done = 1'b0; draw_done = 1'b0;
    step(); step(); step();
    chk("reset_outputs", all_outs(), 32'd0);
    resetn = 1'b1;
    step(); step(); step();
    chk("go_held_no_start", 32'(startgame), 32'd0);
    go = 1'b0;
    step();

    start_game();
    run_frame($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 0, 1'b0);
    run_frame($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 0, 1'b0);
    run_frame(6, 0, 1'b0, 3, 1'b0);
    run_frame(1, 14, 1'b0, 0, 1'b1);
    run_frame($urandom_range(0, 1), 0, 1'b1, 0, 1'b0);
    chk("overrun_once", 32'(ov_seen), 32'd1);
    step();
    chk("over_holds", 32'({startgame, endgame}), 32'd1);
    go = 1'b1;
    step();
    chk("back_to_menu", 32'({startgame, endgame}), 32'd0);
    chk("score_kept", 32'(score), 32'd5);
    go = 1'b0;
    step();

    start_game();
    erase_done = 1'b1;
    w = 0;
    while (draw_req !== 1'b1 && w < 64) begin
      step();
      w++;
    end
    chk("reach_draw", 32'(draw_req), 32'd1);
    erase_done = 1'b0;
    go = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_drops_draw", 32'(draw_req), 32'd0);
    chk("reset_mid_outputs", all_outs(), 32'd0);
    step();
    step();
    chk("reset_hold_outputs", all_outs(), 32'd0);
    resetn = 1'b1;
    step(); step(); step();
    chk("go_held_after_reset", 32'(startgame), 32'd0);
    go = 1'b0;
    step();

    start_game();
    for (int f = 0; f < 300; f++) begin
      run_frame($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 0, 1'b0);
    end
    chk("score_saturated", 32'(score), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_frame_ctrl.md
GAME_FRAME_CTRL -- requirements
Module: game_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_DIV, default 833333, giving clk cycles per game frame (60 Hz at 50 MHz); legal range 4..2^20.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL be on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port go, input, 1, debounced, synchronous, active-high start/acknowledge button level.
REQ-005 The block SHALL have port grav, input, 1, synchronous, active-high gravity-flip button level.
REQ-006 The block SHALL have port collide, input, 1, datapath collision flag, valid in CHECK.
REQ-007 The block SHALL have port erase_done, input, 1, plotter completion for the erase pass.
REQ-008 The block SHALL have port draw_done, input, 1, plotter completion for the draw pass.
REQ-009 The block SHALL have port startgame, output, 1, high in every state except MENU, MENU_WAIT and OVER.
REQ-010 The block SHALL have port init_game, output, 1, one-cycle pulse in START that resets walls and dude.
REQ-011 The block SHALL have port erase_req, output, 1, high exactly while in ERASE.
REQ-012 The block SHALL have port update_en, output, 1, one-cycle pulse while in UPDATE.
REQ-013 The block SHALL have port draw_req, output, 1, high exactly while in DRAW.
REQ-014 The block SHALL have port grav_dir, output, 1, current gravity direction (0 = down, 1 = up).
REQ-015 The block SHALL have port endgame, output, 1, high exactly while in OVER.
REQ-016 The block SHALL have port score, output, 8, count of frames survived.
REQ-017 The block SHALL have port overrun, output, 1, one-cycle pulse on a frame tick lost to an already-pending tick.

Function
REQ-018 The FSM SHALL have states MENU, MENU_WAIT, START, WAIT_TICK, ERASE, UPDATE, CHECK, DRAW and OVER, with Moore outputs only.
REQ-019 The FSM SHALL make these transitions:
- MENU -> MENU_WAIT on a go rising edge (go=1 and registered go_q=0).
- MENU_WAIT -> START when go=0.
- START -> WAIT_TICK unconditionally.
REQ-020 The FSM SHALL make these transitions:
- WAIT_TICK -> ERASE when tick=1 or tick_pending=1.
- ERASE -> UPDATE when erase_done=1.
- UPDATE -> CHECK unconditionally.
- CHECK -> OVER if collide=1, else DRAW.
- DRAW -> WAIT_TICK when draw_done=1.
- OVER -> MENU on a go rising edge.
REQ-021 The frame counter SHALL be 20 bits and SHALL count 0..FRAME_DIV-1, wrapping to 0.
REQ-022 The frame counter SHALL run only while startgame=1 and SHALL be held at 0 otherwise.
REQ-023 The combinational signal tick SHALL be 1 when the counter equals FRAME_DIV-1 and the counter is running.
REQ-024 tick_pending SHALL be set on tick when the FSM is not in WAIT_TICK, and SHALL be cleared on entry to ERASE.
REQ-025 tick while tick_pending=1 SHALL assert overrun for one cycle and SHALL leave tick_pending at 1, so at most one frame is queued.
REQ-026 tick in WAIT_TICK SHALL put erase_req high on the next cycle, giving 1-cycle latency.
REQ-027 erase_req and draw_req SHALL hold until the matching done is sampled high and SHALL drop on the following cycle.
REQ-028 erase_done and draw_done SHALL be ignored outside ERASE and DRAW respectively.
REQ-029 A done already high on the first cycle of ERASE or DRAW SHALL complete that state in one cycle.
REQ-030 A grav rising edge SHALL set grav_flip_req in any state.
REQ-031 In UPDATE, grav_dir SHALL toggle if grav_flip_req=1, and grav_flip_req SHALL clear.
REQ-032 Multiple grav edges within one frame SHALL produce a single toggle.
REQ-033 A grav edge in the UPDATE cycle itself SHALL apply next frame.
REQ-034 grav_flip_req SHALL clear and grav_dir SHALL reset to 0 in START.
REQ-035 score SHALL clear to 0 in START and SHALL increment by 1 in UPDATE, saturating at 8'hFF with no wrap.
REQ-036 score SHALL hold its value through OVER and MENU until the next START.
REQ-037 collide SHALL be sampled only in CHECK.
REQ-038 When a collision occurs, the frame's score increment SHALL already have happened, and that frame SHALL not be drawn.

Reset
REQ-039 resetn=0 SHALL asynchronously force the FSM to MENU and clear to 0 the counter, tick_pending, grav_flip_req, go_q, grav_q, score and grav_dir.
REQ-040 During reset, all outputs SHALL be 0.
REQ-041 Reset asserted mid-frame, including while erase_req or draw_req is high, SHALL drop the request immediately without waiting for done.
REQ-042 After resetn deasserts, the block SHALL stay in MENU until a fresh go rising edge; go already held high at release SHALL not start a game.

Verification
REQ-043 Bench scenario, start: FRAME_DIV=8; press go 3 cycles then release -> init_game pulses once; startgame=1; erase_req rises exactly 8 cycles after START.
REQ-044 Bench scenario, normal frame: erase_done and draw_done each return 2 cycles after req, collide=0 -> per frame one update_en pulse; score 0->1->2; request sequence erase, update, draw, with no overlap.
REQ-045 Bench scenario, overrun: draw_done withheld for 20 cycles (FRAME_DIV=8) -> overrun pulses exactly once; one queued frame starts 1 cycle after draw_done.
REQ-046 Bench scenario, gravity: three grav pulses within one frame -> grav_dir toggles once at UPDATE; a grav pulse during UPDATE -> toggle in the next frame.
REQ-047 Bench scenario, game over: collide=1 in frame 5 -> endgame=1, score=5, no draw_req that frame; go press -> MENU with score still 5; next START clears score to 0.
REQ-048 Bench scenario, reset and saturation: resetn pulsed low mid-DRAW -> draw_req=0 within the same cycle and all outputs 0; separately, 300 frames -> score stays 8'hFF.
